// File: rtl/acc16_status_if.sv
// acc16_status_if: operand stream in, packet result out, both valid/ready.
//   slave  : the accumulate stage (consumes operands, produces the result)
//   master : the producer/consumer side driving operands and out_ready
//   in_*   : operand beat (in_data 16b, in_last ends the packet)
//   out_*  : packet sum, decoded flags, sticky carry/overflow, beat count
interface acc16_status_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             sign;
  logic             zero;
  logic             parity;
  logic             carry;
  logic             overflow;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, sign, zero, parity, carry, overflow, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, sign, zero, parity, carry, overflow, out_count
  );
endinterface

// File: rtl/acc16_status_unit.sv
// acc16_status_unit: accumulates a packet of 16-bit operands and presents the
// modulo-2^16 sum with status flags. Carry and overflow are sticky over the
// packet so the consumer can tell whether any intermediate add wrapped.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous abort, returns to IDLE and clears all state
//   bus    acc16_status_if.slave (operand and result handshakes)
module acc16_status_unit #(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  acc16_status_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, state_nx;
  logic [15:0]      acc;
  logic             carry_s, ovf_s;
  logic [CNT_W-1:0] count;

  logic             accept, done;
  logic [16:0]      sum;
  logic             v;

  // Ready/valid are pure state decodes; no combinational path from the
  // handshake inputs, which costs one bubble cycle per packet.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);

  // A beat that coincides with clr is dropped.
  assign accept = bus.in_valid && (state != HOLD) && !clr;
  assign done   = (state == HOLD) && bus.out_ready;

  assign sum = {1'b0, acc} + {1'b0, bus.in_data};
  assign v   = (acc[15] & bus.in_data[15] & ~sum[15]) |
               (~acc[15] & ~bus.in_data[15] & sum[15]);

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, ACC: if (accept) state_nx = bus.in_last ? HOLD : ACC;
        HOLD:      if (done)   state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // acc is 0 in IDLE, so the first beat simply loads in_data with c=v=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_s <= 1'b0;
      ovf_s   <= 1'b0;
      count   <= '0;
    end else if (clr || done) begin
      acc     <= '0;
      carry_s <= 1'b0;
      ovf_s   <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      acc     <= sum[15:0];
      carry_s <= carry_s | sum[16];
      ovf_s   <= ovf_s | v;
      if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
    end
  end

  // Flags decode from the registered acc, so they always track out_sum.
  assign bus.out_sum   = acc;
  assign bus.sign      = acc[15];
  assign bus.zero      = (acc == 16'h0000);
  assign bus.parity    = ~^acc;
  assign bus.carry     = carry_s;
  assign bus.overflow  = ovf_s;
  assign bus.out_count = count;

endmodule

// File: tb/tb_acc16_status_unit.sv
// Scoreboard bench for acc16_status_unit: expected packet results are pushed
// when a packet is driven and popped when the result is presented in HOLD.
module tb_acc16_status_unit;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  acc16_status_if #(.CNT_W(CNT_W)) bus();

  acc16_status_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0]      sum;
    logic             c;
    logic             v;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pkt[$];

  // Reference result of the first n beats of pkt.
  function automatic exp_t model(input int n);
    exp_t e;
    logic [16:0] s;
    logic [15:0] d;
    e.sum = '0; e.c = 1'b0; e.v = 1'b0; e.cnt = '0;
    for (int i = 0; i < n; i++) begin
      d = pkt[i];
      s = {1'b0, e.sum} + {1'b0, d};
      e.c = e.c | s[16];
      e.v = e.v | ((e.sum[15] & d[15] & ~s[15]) | (~e.sum[15] & ~d[15] & s[15]));
      e.sum = s[15:0];
      if (e.cnt != {CNT_W{1'b1}}) e.cnt = e.cnt + 1'b1;
    end
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".sum"},    bus.out_sum,   e.sum);
    chk({tag, ".sign"},   bus.sign,      e.sum[15]);
    chk({tag, ".zero"},   bus.zero,      e.sum == 16'h0000);
    chk({tag, ".parity"}, bus.parity,    ~^e.sum);
    chk({tag, ".carry"},  bus.carry,     e.c);
    chk({tag, ".ovf"},    bus.overflow,  e.v);
    chk({tag, ".count"},  bus.out_count, e.cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".out_valid"}, bus.out_valid, 1'b0);
    chk({tag, ".in_ready"},  bus.in_ready,  1'b1);
    chk({tag, ".sum"},       bus.out_sum,   16'h0000);
    chk({tag, ".count"},     bus.out_count, '0);
    chk({tag, ".carry"},     bus.carry,     1'b0);
    chk({tag, ".ovf"},       bus.overflow,  1'b0);
    chk({tag, ".sign"},      bus.sign,      1'b0);
    chk({tag, ".zero"},      bus.zero,      1'b1);
    chk({tag, ".parity"},    bus.parity,    1'b1);
  endtask

  // Drive pkt back-to-back, stall the result for `stall` cycles while junk
  // beats are offered, compare against the scoreboard, then optionally
  // complete the output handshake.
  task automatic run_pkt(input string tag, input int stall, input bit complete);
    exp_t e;
    int n;
    n = pkt.size();
    sb.push_back(model(n));
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pkt[i];
      bus.in_last  = (i == n - 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = 16'($urandom);
      e = model(i + 1);
      chk({tag, ".beat_sum"},   bus.out_sum,   e.sum);
      chk({tag, ".beat_carry"}, bus.carry,     e.c);
      chk({tag, ".beat_ovf"},   bus.overflow,  e.v);
      chk({tag, ".beat_count"}, bus.out_count, e.cnt);
      chk({tag, ".beat_vld"},   bus.out_valid, (i == n - 1));
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      bus.in_valid = 1'b1;
      bus.in_last  = 1'($urandom);
      @(negedge clk);
      chk({tag, ".stall_vld"}, bus.out_valid, 1'b1);
      chk({tag, ".stall_rdy"}, bus.in_ready,  1'b0);
      check_out({tag, ".stall"}, model(n));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".vld"}, bus.out_valid, 1'b1);
      check_out(tag, e);
    end
    if (complete) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, ".post_vld"},   bus.out_valid, 1'b0);
      chk({tag, ".post_rdy"},   bus.in_ready,  1'b1);
      chk({tag, ".post_sum"},   bus.out_sum,   16'h0000);
      chk({tag, ".post_count"}, bus.out_count, '0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_vals("rst_rel");

    pkt = '{16'h8fff, 16'h8000};
    run_pkt("p_8fff", 0, 1'b1);

    pkt = '{16'hfffe, 16'h0002};
    run_pkt("p_fffe", 3, 1'b1);

    pkt = '{16'haaaa, 16'h5555};
    run_pkt("p_aaaa", 3, 1'b1);

    pkt = '{16'h7fff, 16'h0001, 16'h8000};
    run_pkt("p_sticky", 1, 1'b1);

    // clr together with a valid beat: beat dropped, back to IDLE.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    bus.in_last  = 1'b0;
    @(posedge clk); #1;
    chk("clr.first_sum", bus.out_sum, 16'h1234);
    bus.in_data = 16'h1111;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_vals("clr");

    pkt = '{16'h0001};
    run_pkt("p_single", 1, 1'b1);

    // Count saturation, then async reset in the middle of HOLD.
    pkt = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    run_pkt("p_sat", 2, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_vals("async_rel");

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/acc16_status_unit.md
# acc16_status_unit

Sequential accumulate-and-flag stage that sits directly downstream of the 16-bit behavioural adder datapath. It accepts a stream of 16-bit operands over a valid/ready handshake, sums them with the same 16-bit add and flag rules as the adder stage, and presents the packet sum with its status flags over a valid/ready handshake. Carry and overflow are held sticky across the packet, so the consumer sees whether any intermediate add wrapped.

## Interface
Parameters:
- CNT_W, 8, width of the accepted-operand counter. It saturates at 2^CNT_W-1.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort. Highest priority after reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  stage can accept an operand.
- in_data  input  16  operand, treated as two's complement for overflow.
- in_last  input  1  marks the final operand of the packet. Qualified by in_valid.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  16  packet sum, modulo 2^16.
- sign  output  1  out_sum[15].
- zero  output  1  out_sum == 0.
- parity  output  1  even parity: XNOR-reduce of out_sum (1 when out_sum has an even number of ones).
- carry  output  1  sticky: OR of carry-out of bit 15 over all adds in the packet.
- overflow  output  1  sticky: OR of signed overflow over all adds in the packet.
- out_count  output  CNT_W  number of operands accepted in the packet.

## Operation
- States: IDLE, ACC, HOLD.
  - IDLE: accumulator, sticky flags and count are all 0. in_ready=1.
  - ACC: in_ready=1.
  - HOLD: in_ready=0 and out_valid=1.
- Accept event: in_valid & in_ready on a rising clk edge. On each accept:
  - acc <= acc + in_data, with a 17-bit internal sum; acc takes bits [15:0].
  - c = sum[16].
  - v = (acc[15] & in_data[15] & ~sum[15]) | (~acc[15] & ~in_data[15] & sum[15]).
  - carry_s |= c; ovf_s |= v; count increments and saturates.
- The first beat adds to acc=0, so it loads in_data with c=0 and v=0.
- State transitions:
  - IDLE, accept with in_last=0 -> ACC.
  - IDLE or ACC, accept with in_last=1 -> HOLD. A single-beat packet is legal.
  - ACC, accept with in_last=0 -> stays in ACC.
  - HOLD, out_valid & out_ready -> IDLE, clearing acc, flags and count.
- sign, zero and parity are decoded from the registered acc, so they are always consistent with out_sum.
- In HOLD, all outputs are held stable until the handshake completes, regardless of in_valid.
- clr=1 forces IDLE from any state on the next edge and clears all state. If clr and an accept happen in the same cycle, the beat is discarded. If clr and the output handshake happen in the same cycle, the result counts as consumed.
- in_data and in_last are ignored when no accept occurs.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - out_valid=0, in_ready=1.
  - out_sum=0, out_count=0, carry=0, overflow=0, sign=0.
  - zero=1 and parity=1, because they are decoded from acc=0.
- Throughput: one operand per cycle while in IDLE or ACC.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N, with the final values, in the same cycle.
- The earliest next accept is the cycle after the output handshake. There is a 1-cycle bubble per packet: in_ready is not combinationally tied to out_ready.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- Reset asserted mid-packet or in HOLD: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset: hold rst_n=0, then release. out_valid=0, in_ready=1, out_sum=0000, zero=1, parity=1, out_count=0.
- Two-beat packet 8fff, then 8000 with last:
  - out_sum=0fff, carry=1, overflow=1, sign=0, zero=0, parity=1, out_count=2.
  - out_valid=1 the cycle after the last accept.
- Two-beat packets with out_ready held low for 3 cycles, then high:
  - fffe, 0002 -> out_sum=0000, zero=1, carry=1, overflow=0.
  - aaaa, 5555 -> out_sum=ffff, sign=1, carry=0, overflow=0, parity=1.
  - Outputs stay stable while stalled. in_ready=0 throughout HOLD.
- Sticky flags, beats 7fff, 0001, 8000 (last):
  - Final out_sum=0000, zero=1, carry=1, overflow=1, out_count=3.
  - Overflow is set by beat 2 and remains set.
- clr mid-packet: accept 1234, then drive clr=1 together with a valid beat 1111.
  - Next cycle: IDLE, out_count=0.
  - A following single-beat packet 0001 (last) gives out_sum=0001, parity=0, out_count=1.
- Asynchronous reset mid-HOLD: assert rst_n=0 between clock edges.
  - out_valid drops immediately and all outputs take reset values.
  - With CNT_W=2 and a 5-beat packet, out_count saturates at 3.
